// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester handshakes and ALU-side bus for the two-requester ALU arbiter.
interface alu_arbiter_if;
   logic        req_valid_0, req_valid_1, req_ready_0, req_ready_1;
   logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
   logic [2:0]  req_op_0, req_op_1;
   logic        rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
   logic [31:0] rsp_result_0, rsp_result_1;
   logic [1:0]  rsp_sign_0, rsp_sign_1;
   logic        rsp_cout_0, rsp_cout_1;
   logic [31:0] alu_reg1, alu_reg2, alu_result;
   logic [2:0]  alu_x;
   logic [1:0]  alu_sign;
   logic        alu_cout;
   modport slave (
      input  req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1, req_op_0, req_op_1,
      input  rsp_ready_0, rsp_ready_1, alu_result, alu_sign, alu_cout,
      output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
      output rsp_result_0, rsp_result_1, rsp_sign_0, rsp_sign_1, rsp_cout_0, rsp_cout_1,
      output alu_reg1, alu_reg2, alu_x
   );
   modport master (
      output req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1, req_op_0, req_op_1,
      output rsp_ready_0, rsp_ready_1, alu_result, alu_sign, alu_cout,
      input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
      input  rsp_result_0, rsp_result_1, rsp_sign_0, rsp_sign_1, rsp_cout_0, rsp_cout_1,
      input  alu_reg1, alu_reg2, alu_x
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational ALU between two requesters,
// one launch per cycle, one outstanding op per requester, two-stage launch/capture pipeline.
module alu_arbiter (
   input  logic         clk,
   input  logic         rst,
   alu_arbiter_if.slave bus
);
   logic rr, owner, inflight, v0, v1;
   logic elig0, elig1, rdy0, rdy1, acc0, acc1;
   always_comb begin
      elig0 = !(inflight && !owner) && !v0;
      elig1 = !(inflight && owner) && !v1;
      rdy0  = !rst && elig0 && (!rr || !(bus.req_valid_1 && elig1));
      rdy1  = !rst && elig1 && (rr || !(bus.req_valid_0 && elig0));
      acc0  = bus.req_valid_0 && rdy0;
      acc1  = bus.req_valid_1 && rdy1;
   end
   assign bus.req_ready_0 = rdy0;
   assign bus.req_ready_1 = rdy1;
   assign bus.rsp_valid_0 = v0 && !rst;
   assign bus.rsp_valid_1 = v1 && !rst;
   always_ff @(posedge clk) begin
      if (rst) begin
         rr               <= 1'b0;
         owner            <= 1'b0;
         inflight         <= 1'b0;
         v0               <= 1'b0;
         v1               <= 1'b0;
         bus.rsp_result_0 <= '0;
         bus.rsp_result_1 <= '0;
         bus.rsp_sign_0   <= '0;
         bus.rsp_sign_1   <= '0;
         bus.rsp_cout_0   <= 1'b0;
         bus.rsp_cout_1   <= 1'b0;
         bus.alu_reg1     <= '0;
         bus.alu_reg2     <= '0;
         bus.alu_x        <= '0;
      end else begin
         inflight <= acc0 || acc1;
         if (acc0 || acc1) begin
            rr           <= acc0;
            owner        <= acc1;
            bus.alu_reg1 <= acc1 ? bus.req_a_1 : bus.req_a_0;
            bus.alu_reg2 <= acc1 ? bus.req_b_1 : bus.req_b_0;
            bus.alu_x    <= acc1 ? bus.req_op_1 : bus.req_op_0;
         end
         if (v0 && bus.rsp_ready_0) v0 <= 1'b0;
         if (v1 && bus.rsp_ready_1) v1 <= 1'b0;
         // an in-flight owner always has its response slot empty, so capture never races a clear
         if (inflight && !owner) begin
            v0               <= 1'b1;
            bus.rsp_result_0 <= bus.alu_result;
            bus.rsp_sign_0   <= bus.alu_sign;
            bus.rsp_cout_0   <= bus.alu_cout;
         end
         if (inflight && owner) begin
            v1               <= 1'b1;
            bus.rsp_result_1 <= bus.alu_result;
            bus.rsp_sign_1   <= bus.alu_sign;
            bus.rsp_cout_1   <= bus.alu_cout;
         end
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench with a behavioural ALU and per-requester response scoreboards.
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cmps = 0, errs = 0, nr0 = 0, nr1 = 0;
   logic [34:0] q0[$], q1[$];
   alu_arbiter_if bus();
   alu_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      logic [32:0] s;
      logic [31:0] r;
      logic c;
      s = {1'b0, a} + {1'b0, b};
      c = 1'b0;
      case (op)
         3'd0: begin r = s[31:0]; c = s[32]; end
         3'd1: begin r = a - b; c = a >= b; end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = a << b[4:0];
         3'd6: r = $signed(a) >>> b[4:0];
         default: r = a * b;
      endcase
      return {r, r == 32'd0 ? 2'b00 : r[31] ? 2'b10 : 2'b01, c};
   endfunction

   assign {bus.alu_result, bus.alu_sign, bus.alu_cout} = alu_f(bus.alu_reg1, bus.alu_reg2, bus.alu_x);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      cmps++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      logic r;
      int k;
      if (i == 0) begin
         bus.req_valid_0 = 1'b1; bus.req_a_0 = a; bus.req_b_0 = b; bus.req_op_0 = op;
      end else begin
         bus.req_valid_1 = 1'b1; bus.req_a_1 = a; bus.req_b_1 = b; bus.req_op_1 = op;
      end
      k = 0;
      #1 r = (i == 0) ? bus.req_ready_0 : bus.req_ready_1;
      while (!r && k < 50) begin
         tick();
         #1 r = (i == 0) ? bus.req_ready_0 : bus.req_ready_1;
         k++;
      end
      chk("send_ready", r, 1);
      tick();
      if (i == 0) bus.req_valid_0 = 1'b0;
      else bus.req_valid_1 = 1'b0;
   endtask

   // scoreboard: push on accept, pop and compare on consumption; reset discards pending work
   always @(negedge clk) begin
      if (rst) begin
         q0.delete();
         q1.delete();
         chk("rst_ready", {bus.req_ready_0, bus.req_ready_1}, 0);
         chk("rst_rsp_valid", {bus.rsp_valid_0, bus.rsp_valid_1}, 0);
      end else begin
         if (bus.req_valid_0 && bus.req_ready_0) q0.push_back(alu_f(bus.req_a_0, bus.req_b_0, bus.req_op_0));
         if (bus.req_valid_1 && bus.req_ready_1) q1.push_back(alu_f(bus.req_a_1, bus.req_b_1, bus.req_op_1));
         if (bus.rsp_valid_0 && bus.rsp_ready_0) begin
            nr0++;
            chk("rsp0_expected", q0.size() != 0, 1);
            if (q0.size() != 0) chk("rsp0", {bus.rsp_result_0, bus.rsp_sign_0, bus.rsp_cout_0}, q0.pop_front());
         end
         if (bus.rsp_valid_1 && bus.rsp_ready_1) begin
            nr1++;
            chk("rsp1_expected", q1.size() != 0, 1);
            if (q1.size() != 0) chk("rsp1", {bus.rsp_result_1, bus.rsp_sign_1, bus.rsp_cout_1}, q1.pop_front());
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n, c0, c1, nboth, nrep, lg, b0, b1;
      logic r0, r1;
      bus.req_valid_0 = 1'b1; bus.req_valid_1 = 1'b0;
      bus.req_a_0 = '0; bus.req_b_0 = '0; bus.req_op_0 = '0;
      bus.req_a_1 = '0; bus.req_b_1 = '0; bus.req_op_1 = '0;
      bus.rsp_ready_0 = 1'b0; bus.rsp_ready_1 = 1'b0;
      tick(); tick();
      chk("rst_alu_reg1", bus.alu_reg1, 0);
      chk("rst_alu_x", bus.alu_x, 0);
      chk("rst_rsp0", {bus.rsp_result_0, bus.rsp_sign_0, bus.rsp_cout_0}, 0);
      chk("rst_rsp1", {bus.rsp_result_1, bus.rsp_sign_1, bus.rsp_cout_1}, 0);
      chk("rst_ready0_held_low", bus.req_ready_0, 0);
      bus.req_valid_0 = 1'b0;
      rst = 1'b0;
      // single request on requester 0
      bus.req_valid_0 = 1'b1; bus.req_a_0 = -32'sd2; bus.req_b_0 = -32'sd4; bus.req_op_0 = 3'd0;
      #1 chk("t1_ready0", bus.req_ready_0, 1);
      tick();
      bus.req_valid_0 = 1'b0;
      #1 chk("t1_launch", {bus.alu_reg1, bus.alu_reg2, bus.alu_x}, {32'hFFFFFFFE, 32'hFFFFFFFC, 3'd0});
      chk("t1_not_yet_valid", bus.rsp_valid_0, 0);
      chk("t1_busy_ready0", bus.req_ready_0, 0);
      tick();
      #1 chk("t1_rsp_valid", bus.rsp_valid_0, 1);
      chk("t1_rsp", {bus.rsp_result_0, bus.rsp_sign_0, bus.rsp_cout_0}, {32'hFFFFFFFA, 2'b10, 1'b1});
      bus.rsp_ready_0 = 1'b1;
      tick();
      #1 chk("t1_cleared", bus.rsp_valid_0, 0);
      chk("t1_reeligible", bus.req_ready_0, 1);
      // simultaneous requests right after reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.rsp_ready_1 = 1'b1;
      bus.req_valid_0 = 1'b1; bus.req_a_0 = 32'd2; bus.req_b_0 = 32'd4; bus.req_op_0 = 3'd1;
      bus.req_valid_1 = 1'b1; bus.req_a_1 = 32'd3; bus.req_b_1 = 32'd7; bus.req_op_1 = 3'd2;
      #1 chk("t2_grant", {bus.req_ready_0, bus.req_ready_1}, 2'b10);
      tick();
      bus.req_valid_0 = 1'b0;
      #1 chk("t2_ready1", bus.req_ready_1, 1);
      chk("t2_launch0", {bus.alu_reg1, bus.alu_x}, {32'd2, 3'd1});
      tick();
      bus.req_valid_1 = 1'b0;
      #1 chk("t2_launch1", {bus.alu_reg1, bus.alu_x}, {32'd3, 3'd2});
      chk("t2_rsp0", {bus.rsp_valid_0, bus.rsp_result_0}, {1'b1, 32'hFFFFFFFE});
      tick();
      #1 chk("t2_rsp1", {bus.rsp_valid_1, bus.rsp_result_1}, {1'b1, 32'd3});
      chk("t2_rsp0_gone", bus.rsp_valid_0, 0);
      tick();
      // backpressure on requester 1 while requester 0 keeps issuing
      bus.rsp_ready_1 = 1'b0;
      send(1, 32'd5, 32'd6, 3'd4);
      tick(); tick();
      n = 0;
      for (int k = 0; k < 6; k++) begin
         bus.req_valid_0 = 1'b1; bus.req_a_0 = 32'd1; bus.req_b_0 = 32'd1; bus.req_op_0 = 3'd0;
         #1 chk("t3_held", {bus.rsp_valid_1, bus.rsp_result_1, bus.req_ready_1}, {1'b1, 32'd3, 1'b0});
         if (bus.req_ready_0) n++;
         tick();
      end
      bus.req_valid_0 = 1'b0;
      chk("t3_req0_issues", n, 2);
      bus.rsp_ready_1 = 1'b1;
      tick();
      #1 chk("t3_rsp1_released", bus.rsp_valid_1, 0);
      tick(); tick();
      // continuous traffic from both requesters, ten ops each
      b0 = nr0; b1 = nr1;
      c0 = 0; c1 = 0; nboth = 0; nrep = 0; lg = -1;
      bus.req_a_0 = 32'd2; bus.req_b_0 = 32'd4; bus.req_op_0 = 3'd5;
      bus.req_a_1 = -32'sd3; bus.req_b_1 = 32'd1; bus.req_op_1 = 3'd6;
      for (int k = 0; k < 200 && (c0 < 10 || c1 < 10); k++) begin
         bus.req_valid_0 = c0 < 10;
         bus.req_valid_1 = c1 < 10;
         #1;
         r0 = bus.req_valid_0 && bus.req_ready_0;
         r1 = bus.req_valid_1 && bus.req_ready_1;
         if (bus.req_ready_0 && bus.req_ready_1) nboth++;
         if (r0) begin if (lg == 0) nrep++; lg = 0; c0++; end
         if (r1) begin if (lg == 1) nrep++; lg = 1; c1++; end
         tick();
      end
      bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
      repeat (4) tick();
      chk("t4_accepts", {c0[7:0], c1[7:0]}, {8'd10, 8'd10});
      chk("t4_single_grant", nboth, 0);
      chk("t4_alternate", nrep, 0);
      chk("t4_rsp_count", {nr0 - b0, nr1 - b1}, {32'd10, 32'd10});
      chk("t4_drained", q0.size() + q1.size(), 0);
      // reset while requester 1's op is in flight
      bus.rsp_ready_1 = 1'b0;
      send(1, -32'sd256, 32'd2, 3'd7);
      rst = 1'b1;
      bus.req_valid_0 = 1'b1;
      #1 chk("t5_rst_ready", {bus.req_ready_0, bus.req_ready_1}, 0);
      tick(); tick();
      #1 chk("t5_alu_cleared", {bus.alu_reg1, bus.alu_reg2, bus.alu_x}, 0);
      chk("t5_rsp1_cleared", {bus.rsp_result_1, bus.rsp_sign_1, bus.rsp_cout_1}, 0);
      chk("t5_rsp0_cleared", {bus.rsp_valid_0, bus.rsp_result_0, bus.rsp_sign_0, bus.rsp_cout_0}, 0);
      bus.req_valid_0 = 1'b0;
      rst = 1'b0;
      bus.rsp_ready_1 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1 chk("t5_no_stale_rsp1", bus.rsp_valid_1, 0);
         tick();
      end
      bus.req_valid_0 = 1'b1; bus.req_a_0 = 32'd9; bus.req_b_0 = 32'd9; bus.req_op_0 = 3'd3;
      bus.req_valid_1 = 1'b1; bus.req_a_1 = 32'd6; bus.req_b_1 = 32'd3; bus.req_op_1 = 3'd1;
      #1 chk("t5_rr_reset", {bus.req_ready_0, bus.req_ready_1}, 2'b10);
      tick();
      bus.req_valid_0 = 1'b0;
      #1 chk("t5_ready1", bus.req_ready_1, 1);
      tick();
      bus.req_valid_1 = 1'b0;
      repeat (4) tick();
      chk("t5_drained", q0.size() + q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end
endmodule
